pipeline_run_monitor: RTL and testbench
=======================================

# pipeline_run_monitor

Synthesizable run-control and retirement monitor that sits beside `core_pip` and watches its writeback stage. It replaces the fixed "run N cycles then stop" approach with parametrised halt detection, drain, watchdog and cycle budgets. It produces pass/fail, performance counters and a write checksum that benches and FPGA builds can both read.

## Interface
- `XLEN`, 32: data/PC width
- `CNT_W`, 32: width of cycle/retire counters
- `MAX_CYCLES`, 1000: cycle budget after reset release; exceeding it sets `timeout`
- `WATCHDOG`, 64: max consecutive cycles without a retirement before `hang`
- `DRAIN_CYCLES`, 4: cycles waited after the halt instruction retires before `done`
- `SIG_REG`, 10: register index whose last written value decides pass/fail (a0)
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `wb_valid`  in  1  an instruction retires this cycle
- `wb_reg_write`  in  1  retiring instruction writes `wb_rd`
- `wb_rd`  in  5  destination register
- `wb_data`  in  XLEN  value written
- `wb_pc`  in  XLEN  PC of retiring instruction
- `wb_inst`  in  32  encoding of retiring instruction
- `cycle_count`  out  CNT_W  cycles spent in RUN/DRAIN
- `retire_count`  out  CNT_W  instructions retired
- `checksum`  out  XLEN  rolling hash of register writes
- `halt_pc`  out  XLEN  PC of halting instruction
- `done`  out  1  run finished normally (sticky)
- `pass`  out  1  valid when `done`: signature register == 0
- `timeout`  out  1  cycle budget exhausted (sticky)
- `hang`  out  1  watchdog expired (sticky)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE, FAIL.
- Reset (async): state IDLE, all outputs and counters 0, signature shadow 0, drain/watchdog counters 0.
- IDLE -> RUN on the first rising edge with `rst` low; no counting in IDLE.
- RUN: `cycle_count` +1 per cycle. Watchdog counter clears on `wb_valid`, otherwise +1.
- Retirement (`wb_valid`=1, in RUN only): `retire_count` +1.
- Writes: if `wb_reg_write` and `wb_rd`!=0, then `checksum <= {checksum[XLEN-2:0],checksum[XLEN-1]} ^ wb_data ^ wb_rd`. Writes to x0 are ignored.
- Signature: if `wb_reg_write` and `wb_rd`==SIG_REG, the shadow is updated with `wb_data`.
- Halt instruction: `wb_inst`==32'h00000073 (ECALL) or 32'h0000006F (`jal x0,0`). On retirement it is counted, `halt_pc <= wb_pc`, and the FSM moves RUN -> DRAIN.
- DRAIN: `cycle_count` keeps counting. Retirements are ignored: no counter, checksum or shadow updates. After DRAIN_CYCLES cycles -> DONE.
- DONE: `done`=1 and `pass` = (shadow==0). All counters freeze.
- RUN -> FAIL when `cycle_count` reaches MAX_CYCLES-1 (sets `timeout`) or the watchdog reaches WATCHDOG-1 (sets `hang`). Both may set in the same cycle. FAIL freezes everything; `done`=0 and `pass`=0.
- Priority in RUN within one cycle: halt retirement beats timeout/hang. The halt instruction is still counted.
- Counters saturate at all-ones; they never wrap.
- `rst` asserted mid-run returns the block to IDLE immediately with all-zero outputs.

## Timing
- All outputs are registered. Flag/counter updates are visible one cycle after the causing edge.
- `done` rises exactly DRAIN_CYCLES+1 edges after the edge sampling the halt retirement.
- `timeout` is high after exactly MAX_CYCLES counted RUN cycles.
- A retirement on the same edge that leaves IDLE is not counted.

## Structure
- Shared package `rv_sim_pkg`: ECALL/JAL-self encodings, state enum, x0 index.
- One sub-module: `sat_counter` (parametrised width, enable, clear, saturate). It is instantiated for cycle, retire, watchdog and drain counters.
- No memories; roughly 200 lines total.

## Test plan
- Reset held 20 ns, then 5 retirements with no halt, MAX_CYCLES=50 -> `timeout`=1 after cycle 50; `retire_count`=5; `done`=0.
- Writes a0=0 then ECALL at PC 0x40, DRAIN_CYCLES=4 -> `done`=1 five edges later, `pass`=1, `halt_pc`=0x40.
- Write a0=1 then `jal x0,0` -> `done`=1, `pass`=0. Retirements during DRAIN do not change `retire_count` or `checksum`.
- Single retirement then silence, WATCHDOG=8 -> `hang`=1 after 8 idle cycles, `timeout`=0.
- Writes 0x11 to x5 and 0xFFFF to x0 -> `checksum`=0x11^5=0x14. The x0 write is ignored.
- Assert `rst` mid-RUN with counters nonzero -> all outputs 0 asynchronously. Release -> counting restarts from 0.

Source files
------------

// File: rtl/rv_sim_pkg.sv
// Shared encodings and run-control state type for the simulation/run monitor.
package rv_sim_pkg;

    localparam logic [31:0] INST_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INST_JAL_SELF = 32'h0000_006F;
    localparam logic [4:0]  REG_X0        = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAIL
    } run_state_t;

    // Either encoding marks the end of a test program.
    function automatic logic is_halt(input logic [31:0] inst);
        return (inst == INST_ECALL) || (inst == INST_JAL_SELF);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        return (&value) ? value : value + WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Watches the writeback stage: detects halt, drains, enforces cycle and watchdog budgets,
// and reports pass/fail, retirement counters and a checksum of register writes.
module pipeline_run_monitor
    import rv_sim_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 1000,
    parameter int WATCHDOG     = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int SIG_REG      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic [31:0]      wb_inst,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [XLEN-1:0]  checksum,
    output logic [XLEN-1:0]  halt_pc,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             hang
);

    run_state_t       state, state_next;
    logic [CNT_W-1:0] watchdog_count;
    logic [CNT_W-1:0] drain_count;
    logic [XLEN-1:0]  sig_shadow;

    logic in_run, in_drain, retire, reg_write, halt_retire;
    logic budget_hit, watchdog_hit, drain_over;
    logic set_timeout, set_hang, set_done;

    assign in_run       = (state == ST_RUN);
    assign in_drain     = (state == ST_DRAIN);
    assign retire       = in_run && wb_valid;
    assign reg_write    = retire && wb_reg_write && (wb_rd != REG_X0);
    assign halt_retire  = retire && is_halt(wb_inst);
    assign budget_hit   = in_run && (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign watchdog_hit = in_run && !wb_valid && (watchdog_count == CNT_W'(WATCHDOG - 1));
    assign drain_over   = in_drain && (drain_count == CNT_W'(DRAIN_CYCLES));

    sat_counter #(.WIDTH(CNT_W)) u_cycle (
        .clk(clk), .rst(rst), .clr(1'b0), .en(in_run || in_drain), .count(cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retire (
        .clk(clk), .rst(rst), .clr(1'b0), .en(retire), .count(retire_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_watchdog (
        .clk(clk), .rst(rst), .clr(retire), .en(in_run && !wb_valid), .count(watchdog_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_drain (
        .clk(clk), .rst(rst), .clr(halt_retire), .en(in_drain), .count(drain_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A retiring halt wins over a budget or watchdog expiry in the same cycle.
    always_comb begin
        state_next  = state;
        set_timeout = 1'b0;
        set_hang    = 1'b0;
        set_done    = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN: begin
                if (halt_retire) begin
                    state_next = ST_DRAIN;
                end else if (budget_hit || watchdog_hit) begin
                    state_next  = ST_FAIL;
                    set_timeout = budget_hit;
                    set_hang    = watchdog_hit;
                end
            end
            ST_DRAIN: begin
                if (drain_over) begin
                    state_next = ST_DONE;
                    set_done   = 1'b1;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum   <= '0;
            sig_shadow <= '0;
            halt_pc    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            hang       <= 1'b0;
        end else begin
            if (reg_write) begin
                checksum <= {checksum[XLEN-2:0], checksum[XLEN-1]} ^ wb_data ^ XLEN'(wb_rd);
                if (wb_rd == 5'(SIG_REG)) begin
                    sig_shadow <= wb_data;
                end
            end
            if (halt_retire) begin
                halt_pc <= wb_pc;
            end
            if (set_done) begin
                done <= 1'b1;
                pass <= (sig_shadow == '0);
            end
            timeout <= timeout | set_timeout;
            hang    <= hang | set_hang;
        end
    end

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Directed bench: a vector table for halt/drain/checksum plus sequences for budgets and reset.
module tb_pipeline_run_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_inst = '0;

    logic [31:0] a_cycle, a_retire, a_chk, a_hpc;
    logic        a_done, a_pass, a_timeout, a_hang;
    logic [31:0] b_cycle, b_retire, b_chk, b_hpc;
    logic        b_done, b_pass, b_timeout, b_hang;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Short cycle budget, generous watchdog
    pipeline_run_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(50), .WATCHDOG(64),
                           .DRAIN_CYCLES(4), .SIG_REG(10)) dut_a (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .cycle_count(a_cycle), .retire_count(a_retire), .checksum(a_chk), .halt_pc(a_hpc),
        .done(a_done), .pass(a_pass), .timeout(a_timeout), .hang(a_hang)
    );

    // Short watchdog, generous cycle budget
    pipeline_run_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(1000), .WATCHDOG(8),
                           .DRAIN_CYCLES(4), .SIG_REG(10)) dut_b (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .cycle_count(b_cycle), .retire_count(b_retire), .checksum(b_chk), .halt_pc(b_hpc),
        .done(b_done), .pass(b_pass), .timeout(b_timeout), .hang(b_hang)
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] chk;
        logic        dn;
        logic        ps;
        logic [31:0] hpc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [31:0] data, input logic [31:0] pc, input logic [31:0] inst);
        wb_valid     = v;
        wb_reg_write = we;
        wb_rd        = rd;
        wb_data      = data;
        wb_pc        = pc;
        wb_inst      = inst;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, ".cycle"},   a_cycle, 32'd0);
        check({tag, ".retire"},  a_retire, 32'd0);
        check({tag, ".chk"},     a_chk, 32'd0);
        check({tag, ".halt_pc"}, a_hpc, 32'd0);
        check({tag, ".done"},    {31'd0, a_done}, 32'd0);
        check({tag, ".pass"},    {31'd0, a_pass}, 32'd0);
        check({tag, ".timeout"}, {31'd0, a_timeout}, 32'd0);
        check({tag, ".hang"},    {31'd0, a_hang}, 32'd0);
    endtask

    // Holds reset 20 ns, releases between edges, then lets the IDLE->RUN edge pass.
    task automatic do_reset(input string tag);
        step();
        rst = 1'b1;
        idle();
        #1;
        check_zero_a(tag);
        #19;
        rst = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'h11,   32'h10, 32'h13, 32'd1, 32'd1, 32'h14, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  32'hFFFF, 32'h14, 32'h13, 32'd2, 32'd2, 32'h14, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 5'd10, 32'h0,    32'h18, 32'h13, 32'd3, 32'd3, 32'h22, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 5'd0,  32'h0,    32'h40, 32'h73, 32'd4, 32'd4, 32'h22, 1'b0, 1'b0, 32'h40};
        vecs[4] = '{1'b1, 1'b1, 5'd5,  32'h99,   32'h44, 32'h13, 32'd5, 32'd4, 32'h22, 1'b0, 1'b0, 32'h40};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,  32'h0,  32'd6, 32'd4, 32'h22, 1'b0, 1'b0, 32'h40};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,  32'h0,  32'd7, 32'd4, 32'h22, 1'b0, 1'b0, 32'h40};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,  32'h0,  32'd8, 32'd4, 32'h22, 1'b0, 1'b0, 32'h40};
        vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,  32'h0,  32'd9, 32'd4, 32'h22, 1'b1, 1'b1, 32'h40};
        vecs[9] = '{1'b1, 1'b1, 5'd10, 32'h5,    32'h50, 32'h73, 32'd9, 32'd4, 32'h22, 1'b1, 1'b1, 32'h40};

        // Table: checksum with x0 ignored, ECALL halt, drain, done/pass, freeze
        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].pc, vecs[i].inst);
            step();
            check($sformatf("vec%0d.a.cycle", i),   a_cycle, vecs[i].cyc);
            check($sformatf("vec%0d.a.retire", i),  a_retire, vecs[i].ret);
            check($sformatf("vec%0d.a.chk", i),     a_chk, vecs[i].chk);
            check($sformatf("vec%0d.a.done", i),    {31'd0, a_done}, {31'd0, vecs[i].dn});
            check($sformatf("vec%0d.a.pass", i),    {31'd0, a_pass}, {31'd0, vecs[i].ps});
            check($sformatf("vec%0d.a.halt_pc", i), a_hpc, vecs[i].hpc);
            check($sformatf("vec%0d.b.chk", i),     b_chk, vecs[i].chk);
            check($sformatf("vec%0d.b.done", i),    {31'd0, b_done}, {31'd0, vecs[i].dn});
        end

        // a0=1 then jal x0,0; retirements during drain are ignored
        do_reset("rst1");
        drive(1'b1, 1'b1, 5'd10, 32'h1, 32'h20, 32'h13);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h24, 32'h6F);
        step();
        check("jal.retire", a_retire, 32'd2);
        check("jal.chk", a_chk, 32'h0B);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 5'd3, 32'h55, 32'h28, 32'h13);
            step();
        end
        check("drain.retire", a_retire, 32'd2);
        check("drain.chk", a_chk, 32'h0B);
        idle();
        step();
        step();
        check("jal.done_early", {31'd0, a_done}, 32'd0);
        step();
        check("jal.done", {31'd0, a_done}, 32'd1);
        check("jal.pass", {31'd0, a_pass}, 32'd0);
        check("jal.halt_pc", a_hpc, 32'h24);
        check("jal.cycle", a_cycle, 32'd7);

        // Five retirements then silence: cycle budget of 50 expires
        do_reset("rst2");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 32'(i * 4), 32'h13);
            step();
        end
        idle();
        for (int i = 0; i < 44; i++) step();
        check("to.cycle49", a_cycle, 32'd49);
        check("to.early", {31'd0, a_timeout}, 32'd0);
        step();
        check("to.timeout", {31'd0, a_timeout}, 32'd1);
        check("to.cycle", a_cycle, 32'd50);
        check("to.retire", a_retire, 32'd5);
        check("to.done", {31'd0, a_done}, 32'd0);
        check("to.hang", {31'd0, a_hang}, 32'd0);
        step();
        check("to.frozen", a_cycle, 32'd50);

        // Single retirement then silence: watchdog of 8 expires
        do_reset("rst3");
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h13);
        step();
        idle();
        for (int i = 0; i < 7; i++) step();
        check("hang.early", {31'd0, b_hang}, 32'd0);
        step();
        check("hang.hang", {31'd0, b_hang}, 32'd1);
        check("hang.timeout", {31'd0, b_timeout}, 32'd0);
        check("hang.retire", b_retire, 32'd1);
        check("hang.cycle", b_cycle, 32'd9);
        check("hang.done", {31'd0, b_done}, 32'd0);

        // Halt on the same edge the budget would expire: halt wins
        do_reset("rst4");
        for (int i = 0; i < 49; i++) step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h80, 32'h73);
        step();
        idle();
        check("prio.timeout", {31'd0, a_timeout}, 32'd0);
        check("prio.retire", a_retire, 32'd1);
        check("prio.cycle", a_cycle, 32'd50);
        check("prio.halt_pc", a_hpc, 32'h80);
        for (int i = 0; i < 4; i++) step();
        check("prio.done_early", {31'd0, a_done}, 32'd0);
        step();
        check("prio.done", {31'd0, a_done}, 32'd1);
        check("prio.pass", {31'd0, a_pass}, 32'd1);
        check("prio.timeout2", {31'd0, a_timeout}, 32'd0);

        // Mid-run reset clears outputs asynchronously; counting restarts
        do_reset("rst5");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd5, 32'h7, 32'h0, 32'h13);
            step();
        end
        check("mid.cycle", a_cycle, 32'd3);
        check("mid.retire", a_retire, 32'd3);
        check("mid.chk", a_chk, 32'h0E);
        rst = 1'b1;
        #2;
        check_zero_a("mid.async");
        #10;
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 32'h7, 32'h0, 32'h13);
        step();
        check("idle_edge.retire", a_retire, 32'd0);
        check("idle_edge.chk", a_chk, 32'd0);
        check("idle_edge.cycle", a_cycle, 32'd0);
        idle();
        step();
        check("restart.cycle", a_cycle, 32'd1);
        check("restart.retire", a_retire, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
